sat_counter_bank: RTL and testbench
===================================

SAT_COUNTER_BANK -- requirements
Module: sat_counter_bank

Interface
REQ-001 Parameter WIDTH, default 32, counter width in bits (>=2).
REQ-002 Parameter NCH, default 4, number of independent counter channels (>=1).
REQ-003 Parameter SAT_MODE, default 1; 1 = saturating arithmetic, 0 = modular wrap.
REQ-004 Derived constant CW = max(1, clog2(NCH)), channel index width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  command offered this cycle.
REQ-008 cmd_ready  out  1  block accepts command this cycle.
REQ-009 cmd_op  in  2  00 NOP, 01 ADD, 10 SUB, 11 CLR.
REQ-010 cmd_ch  in  CW  target channel.
REQ-011 cmd_x  in  WIDTH  unsigned operand for ADD/SUB.
REQ-012 clr_all  in  1  pulse; start a sweep clearing every channel.
REQ-013 rd_en  in  1  read request.
REQ-014 rd_ch  in  CW  channel to read.
REQ-015 rd_valid  out  1  rd_data/rd_sat valid this cycle.
REQ-016 rd_data  out  WIDTH  channel count.
REQ-017 rd_sat  out  1  channel sticky saturation/wrap flag.
REQ-018 busy  out  1  sweep in progress.

Function
REQ-019 Command transfers when cmd_valid && cmd_ready; no other cycle modifies counters except sweep.
REQ-020 ADD: SAT_MODE=1 -> cnt = min(cnt+x, 2^WIDTH-1) via WIDTH+1-bit sum carry; SAT_MODE=0 -> cnt = (cnt+x) mod 2^WIDTH.
REQ-021 SUB: SAT_MODE=1 -> cnt = max(cnt-x, 0) via borrow; SAT_MODE=0 -> modular subtract.
REQ-022 Carry (ADD) or borrow (SUB) out of WIDTH bits sets that channel's sticky flag, in both modes; x=0 never sets it.
REQ-023 CLR sets channel count and sticky flag to 0.
REQ-024 NOP transfers and changes nothing.
REQ-025 cmd_ch >= NCH: command accepted and discarded, no state change.
REQ-026 Read latency one cycle: rd_en at cycle n -> rd_valid=1 with data at cycle n+1; rd_valid=0 otherwise.
REQ-027 Read returns pre-update value when a command hits the same channel in the same cycle (read-before-write).
REQ-028 rd_ch >= NCH: rd_valid=1, rd_data=0, rd_sat=0.
REQ-029 FSM states IDLE, SWEEP; IDLE->SWEEP on clr_all; SWEEP clears channel idx 0..NCH-1, one per cycle; SWEEP->IDLE after idx NCH-1.
REQ-030 cmd_ready = (state==IDLE) && !clr_all; busy = (state==SWEEP).
REQ-031 clr_all during SWEEP ignored (no restart).
REQ-032 Reads permitted during SWEEP; return current (partially cleared) contents.
REQ-033 Sweep duration exactly NCH cycles; busy high exactly NCH cycles.

Reset
REQ-034 reset asserted: all counts 0, sticky flags 0, state IDLE, sweep index 0, rd_valid 0, rd_data 0, rd_sat 0, immediately (asynchronous).
REQ-035 reset mid-sweep or mid-read aborts the operation; no pending rd_valid after release.
REQ-036 First command accepted on first rising edge after reset deasserts.

Structure
REQ-037 Shared package holds op encoding constants (OP_NOP/ADD/SUB/CLR) and FSM state typedef.
REQ-038 One sub-module sat_alu: combinational WIDTH-parametrised add/sub with SAT_MODE, outputs result and overflow flag.
REQ-039 Counters held as NCH-entry register array, not inferred RAM.

Verification
REQ-040 WIDTH=8, SAT_MODE=1: ADD 200 then ADD 100 on ch1 -> read ch1 = 255, rd_sat=1.
REQ-041 WIDTH=8, SAT_MODE=0: ADD 200 then ADD 100 on ch1 -> read ch1 = 44, rd_sat=1.
REQ-042 SAT_MODE=1: ch2=5, SUB 7 -> 0, rd_sat=1; SUB 0 on ch3=0 -> 0, rd_sat=0.
REQ-043 NCH=4, all channels nonzero, clr_all pulse -> busy/cmd_ready=0 for 4 cycles, command held valid accepted on cycle 5, all reads 0.
REQ-044 Same-cycle ADD 3 and rd_en on ch0=10 -> rd_data=10 next cycle, following read 13.
REQ-045 Assert reset at sweep cycle 2 -> outputs 0 immediately, busy=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/sat_counter_bank_pkg.sv
// ----------------------------------------------------------------------------
// sat_counter_bank_pkg : command encodings and FSM state type for the counter bank
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sat_counter_bank_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_alu.sv
// ----------------------------------------------------------------------------
// sat_alu : WIDTH-bit add/sub with optional saturation and carry/borrow flag
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_alu #(
  parameter int WIDTH    = 32,
  parameter int SAT_MODE = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_ovf;

  assign w_sum  = {1'b0, a_i} + {1'b0, x_i};
  assign w_diff = {1'b0, a_i} - {1'b0, x_i};

  // The extra top bit is the carry for ADD and the borrow for SUB.
  always_comb begin
    w_ovf = sub_i ? w_diff[WIDTH] : w_sum[WIDTH];
    res_o = sub_i ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
    if ((SAT_MODE != 0) && w_ovf) begin
      res_o = sub_i ? '0 : '1;
    end
  end

  assign ovf_o = w_ovf;

endmodule

`default_nettype wire

// File: rtl/sat_counter_bank.sv
// ----------------------------------------------------------------------------
// sat_counter_bank : NCH saturating/wrapping counters with sticky overflow flags,
//                    one-cycle reads and a clear-all sweep. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter_bank
  import sat_counter_bank_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NCH      = 4,
  parameter int SAT_MODE = 1,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CW-1:0]    cmd_ch_i,
  input  logic [WIDTH-1:0] cmd_x_i,
  input  logic             clr_all_i,
  input  logic             rd_en_i,
  input  logic [CW-1:0]    rd_ch_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_sat_o,
  output logic             busy_o
);

  localparam logic [CW:0]   c_NCH  = (CW+1)'(NCH);
  localparam logic [CW-1:0] c_LAST = CW'(NCH - 1);

  state_e           state_q;
  logic [CW-1:0]    idx_q;
  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [NCH-1:0]   sat_q;
  logic [NCH-1:0]   sat_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_sat_q;

  logic             w_cmd_hit;
  logic             w_rd_hit;
  logic             w_fire;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;

  assign cmd_ready_o = (state_q == ST_IDLE) && !clr_all_i;
  assign busy_o      = (state_q == ST_SWEEP);

  // Out-of-range channels still handshake but never touch state.
  assign w_cmd_hit = ({1'b0, cmd_ch_i} < c_NCH);
  assign w_rd_hit  = ({1'b0, rd_ch_i} < c_NCH);
  assign w_fire    = cmd_valid_i && cmd_ready_o && w_cmd_hit;
  assign w_cur     = w_cmd_hit ? cnt_q[cmd_ch_i] : '0;

  sat_alu #(
    .WIDTH    (WIDTH),
    .SAT_MODE (SAT_MODE)
  ) u_alu (
    .a_i   (w_cur),
    .x_i   (cmd_x_i),
    .sub_i (cmd_op_i == OP_SUB),
    .res_o (w_alu_res),
    .ovf_o (w_alu_ovf)
  );

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q == ST_SWEEP) && (idx_q == CW'(i))) begin
        cnt_d[i] = '0;
        sat_d[i] = 1'b0;
      end else if (w_fire && (cmd_ch_i == CW'(i))) begin
        case (cmd_op_i)
          OP_ADD, OP_SUB: begin
            cnt_d[i] = w_alu_res;
            sat_d[i] = sat_q[i] | w_alu_ovf;
          end
          OP_CLR: begin
            cnt_d[i] = '0;
            sat_d[i] = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      sat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (clr_all_i) begin
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (idx_q == c_LAST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reads sample the pre-update registers, giving read-before-write ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_sat_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= w_rd_hit ? cnt_q[rd_ch_i] : '0;
        rd_sat_q  <= w_rd_hit ? sat_q[rd_ch_i] : 1'b0;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_sat_o   = rd_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_sat_counter_bank.sv
// ----------------------------------------------------------------------------
// tb_sat_counter_bank : directed bench for saturating, wrapping and 3-channel builds
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sat_counter_bank;
  import sat_counter_bank_pkg::*;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [1:0] cmd_ch;
  logic [7:0] cmd_x;
  logic       clr_all;
  logic       rd_en;
  logic [1:0] rd_ch;

  logic       s_cmd_ready, s_rd_valid, s_rd_sat, s_busy;
  logic [7:0] s_rd_data;
  logic       w_cmd_ready, w_rd_valid, w_rd_sat, w_busy;
  logic [7:0] w_rd_data;
  logic       t_cmd_ready, t_rd_valid, t_rd_sat, t_busy;
  logic [7:0] t_rd_data;

  int checks   = 0;
  int failures = 0;

  sat_counter_bank #(.WIDTH(8), .NCH(4), .SAT_MODE(1)) dut_sat (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(s_cmd_ready),
    .cmd_op_i(cmd_op), .cmd_ch_i(cmd_ch), .cmd_x_i(cmd_x), .clr_all_i(clr_all),
    .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data),
    .rd_sat_o(s_rd_sat), .busy_o(s_busy)
  );

  sat_counter_bank #(.WIDTH(8), .NCH(4), .SAT_MODE(0)) dut_wrap (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(w_cmd_ready),
    .cmd_op_i(cmd_op), .cmd_ch_i(cmd_ch), .cmd_x_i(cmd_x), .clr_all_i(clr_all),
    .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_valid_o(w_rd_valid), .rd_data_o(w_rd_data),
    .rd_sat_o(w_rd_sat), .busy_o(w_busy)
  );

  sat_counter_bank #(.WIDTH(8), .NCH(3), .SAT_MODE(1)) dut_three (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(t_cmd_ready),
    .cmd_op_i(cmd_op), .cmd_ch_i(cmd_ch), .cmd_x_i(cmd_x), .clr_all_i(clr_all),
    .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_valid_o(t_rd_valid), .rd_data_o(t_rd_data),
    .rd_sat_o(t_rd_sat), .busy_o(t_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_cmd(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] x);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_x = x;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] ch);
    rd_en = 1'b1; rd_ch = ch;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (s_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %0d expected 0", s_rd_valid); end
    checks++; if (s_rd_data !== 8'd0) begin failures++; $display("FAIL reset_rd_data: got %0d expected 0", s_rd_data); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", s_busy); end
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_ch = 2'd0; cmd_x = 8'd5;
    #1;
    checks++; if (s_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %0d expected 1", s_cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    do_read(2'd0);
    checks++; if (s_rd_data !== 8'd5 || s_rd_valid !== 1'b1) begin failures++; $display("FAIL first_cmd: got %0d valid %0d expected 5 valid 1", s_rd_data, s_rd_valid); end
  endtask

  task automatic test_add_sat();
    do_cmd(OP_ADD, 2'd1, 8'd200);
    do_read(2'd1);
    checks++; if (s_rd_data !== 8'd200 || s_rd_sat !== 1'b0) begin failures++; $display("FAIL add_first: got %0d sat %0d expected 200 sat 0", s_rd_data, s_rd_sat); end
    do_cmd(OP_ADD, 2'd1, 8'd100);
    do_read(2'd1);
    checks++; if (s_rd_data !== 8'd255 || s_rd_sat !== 1'b1) begin failures++; $display("FAIL add_sat: got %0d sat %0d expected 255 sat 1", s_rd_data, s_rd_sat); end
    checks++; if (w_rd_data !== 8'd44 || w_rd_sat !== 1'b1) begin failures++; $display("FAIL add_wrap: got %0d sat %0d expected 44 sat 1", w_rd_data, w_rd_sat); end
    checks++; if (t_rd_data !== 8'd255 || t_rd_sat !== 1'b1) begin failures++; $display("FAIL add_sat_nch3: got %0d sat %0d expected 255 sat 1", t_rd_data, t_rd_sat); end
  endtask

  task automatic test_sub();
    do_cmd(OP_ADD, 2'd2, 8'd5);
    do_cmd(OP_SUB, 2'd2, 8'd7);
    do_read(2'd2);
    checks++; if (s_rd_data !== 8'd0 || s_rd_sat !== 1'b1) begin failures++; $display("FAIL sub_sat: got %0d sat %0d expected 0 sat 1", s_rd_data, s_rd_sat); end
    checks++; if (w_rd_data !== 8'd254 || w_rd_sat !== 1'b1) begin failures++; $display("FAIL sub_wrap: got %0d sat %0d expected 254 sat 1", w_rd_data, w_rd_sat); end
    do_cmd(OP_SUB, 2'd3, 8'd0);
    do_read(2'd3);
    checks++; if (s_rd_data !== 8'd0 || s_rd_sat !== 1'b0) begin failures++; $display("FAIL sub_zero: got %0d sat %0d expected 0 sat 0", s_rd_data, s_rd_sat); end
  endtask

  task automatic test_clr_nop();
    do_cmd(OP_CLR, 2'd1, 8'd0);
    do_cmd(OP_NOP, 2'd2, 8'd50);
    do_read(2'd1);
    checks++; if (s_rd_data !== 8'd0 || s_rd_sat !== 1'b0) begin failures++; $display("FAIL clr_cmd: got %0d sat %0d expected 0 sat 0", s_rd_data, s_rd_sat); end
    do_read(2'd2);
    checks++; if (w_rd_data !== 8'd254 || w_rd_sat !== 1'b1) begin failures++; $display("FAIL nop: got %0d sat %0d expected 254 sat 1", w_rd_data, w_rd_sat); end
  endtask

  task automatic test_out_of_range();
    do_cmd(OP_ADD, 2'd3, 8'd9);
    do_read(2'd3);
    checks++; if (s_rd_data !== 8'd9) begin failures++; $display("FAIL oor_inrange: got %0d expected 9", s_rd_data); end
    checks++; if (t_rd_valid !== 1'b1 || t_rd_data !== 8'd0 || t_rd_sat !== 1'b0) begin failures++; $display("FAIL oor_read: got valid %0d data %0d sat %0d expected 1 0 0", t_rd_valid, t_rd_data, t_rd_sat); end
    @(posedge clk); #1;
    checks++; if (s_rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_idle: got %0d expected 0", s_rd_valid); end
  endtask

  task automatic test_back_to_back();
    do_cmd(OP_CLR, 2'd0, 8'd0);
    do_cmd(OP_ADD, 2'd0, 8'd10);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_ch = 2'd0; cmd_x = 8'd3;
    rd_en = 1'b1; rd_ch = 2'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rd_en = 1'b0;
    checks++; if (s_rd_data !== 8'd10) begin failures++; $display("FAIL rbw_old: got %0d expected 10", s_rd_data); end
    do_read(2'd0);
    checks++; if (s_rd_data !== 8'd13) begin failures++; $display("FAIL rbw_new: got %0d expected 13", s_rd_data); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_cnt [4];
    do_cmd(OP_ADD, 2'd1, 8'd1);
    do_cmd(OP_ADD, 2'd2, 8'd4);
    clr_all = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_ch = 2'd0; cmd_x = 8'd7;
    #1;
    checks++; if (s_cmd_ready !== 1'b0) begin failures++; $display("FAIL sweep_start_ready: got %0d expected 0", s_cmd_ready); end
    @(posedge clk); #1;
    clr_all = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (s_busy !== 1'b1 || s_cmd_ready !== 1'b0) begin failures++; $display("FAIL sweep_busy_%0d: got busy %0d ready %0d expected 1 0", k, s_busy, s_cmd_ready); end
      if (k == 1) begin rd_en = 1'b1; rd_ch = 2'd3; end
      if (k == 2) begin
        rd_en = 1'b0;
        clr_all = 1'b1;
        checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'd9) begin failures++; $display("FAIL sweep_read: got valid %0d data %0d expected 1 9", s_rd_valid, s_rd_data); end
      end
      if (k == 3) clr_all = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (s_busy !== 1'b0 || s_cmd_ready !== 1'b1) begin failures++; $display("FAIL sweep_end: got busy %0d ready %0d expected 0 1", s_busy, s_cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_cnt[0] = 8'd7; exp_cnt[1] = 8'd0; exp_cnt[2] = 8'd0; exp_cnt[3] = 8'd0;
    for (int c = 0; c < 4; c++) begin
      do_read(2'(c));
      checks++; if (s_rd_data !== exp_cnt[c] || s_rd_sat !== 1'b0 || w_rd_sat !== 1'b0) begin failures++; $display("FAIL sweep_ch%0d: got %0d sat %0d/%0d expected %0d sat 0", c, s_rd_data, s_rd_sat, w_rd_sat, exp_cnt[c]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_cmd(OP_ADD, 2'd3, 8'd20);
    rd_en = 1'b1; rd_ch = 2'd0;
    clr_all = 1'b1;
    @(posedge clk); #1;
    clr_all = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_busy !== 1'b1 || s_rd_data !== 8'd7) begin failures++; $display("FAIL pre_reset: got busy %0d data %0d expected 1 7", s_busy, s_rd_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if (s_busy !== 1'b0 || s_rd_valid !== 1'b0 || s_rd_data !== 8'd0 || s_rd_sat !== 1'b0) begin failures++; $display("FAIL async_reset: got busy %0d valid %0d data %0d sat %0d expected 0 0 0 0", s_busy, s_rd_valid, s_rd_data, s_rd_sat); end
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_rd_valid !== 1'b0 || s_busy !== 1'b0 || s_cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset: got valid %0d busy %0d ready %0d expected 0 0 1", s_rd_valid, s_busy, s_cmd_ready); end
    do_read(2'd3);
    checks++; if (s_rd_data !== 8'd0) begin failures++; $display("FAIL reset_cleared: got %0d expected 0", s_rd_data); end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_ch = 2'd0; cmd_x = 8'd0;
    clr_all = 1'b0; rd_en = 1'b0; rd_ch = 2'd0;
    test_reset();
    test_add_sat();
    test_sub();
    test_clr_nop();
    test_out_of_range();
    test_back_to_back();
    test_sweep();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
